// File: rtl/instruction_buffer_mux.sv
// rtl/instruction_buffer_mux.sv - fetch-to-decode instruction queue with RV32 field split
//
// Ports:
//   clk_in          rising-edge clock
//   reset_in        synchronous active-high reset (pointers and count only)
//   flush_in        discard all queued entries, present NOP fields
//   push_valid_in   fetch offers mp_instr_in / pc_in
//   push_ready_out  queue accepts the offer this cycle
//   mp_instr_in     fetched instruction word
//   pc_in           PC of mp_instr_in
//   pop_ready_in    decode consumes the head entry
//   pop_valid_out   head entry is valid
//   pc_out          PC of head entry, 0 when NOP presented
//   opcode_out      head[6:0]
//   funct3_out      head[14:12]
//   funct7_out      head[31:25]
//   rs1addr_out     head[19:15]
//   rs2addr_out     head[24:20]
//   rdaddr_out      head[11:7]
//   csr_addr_out    head[31:20]
//   instr_out       head[31:7]
//   count_out       number of valid entries, 0..DEPTH

module instruction_buffer_mux #(
    parameter int          DEPTH     = 4,
    parameter int          PC_W      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic                       clk_in,
    input  logic                       reset_in,
    input  logic                       flush_in,
    input  logic                       push_valid_in,
    output logic                       push_ready_out,
    input  logic [31:0]                mp_instr_in,
    input  logic [PC_W-1:0]            pc_in,
    input  logic                       pop_ready_in,
    output logic                       pop_valid_out,
    output logic [PC_W-1:0]            pc_out,
    output logic [6:0]                 opcode_out,
    output logic [2:0]                 funct3_out,
    output logic [6:0]                 funct7_out,
    output logic [4:0]                 rs1addr_out,
    output logic [4:0]                 rs2addr_out,
    output logic [4:0]                 rdaddr_out,
    output logic [11:0]                csr_addr_out,
    output logic [24:0]                instr_out,
    output logic [$clog2(DEPTH):0]     count_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // Storage is deliberately left unreset; only pointers and count clear.
    logic [31:0]     instr_mem [DEPTH];
    logic [PC_W-1:0] pc_mem    [DEPTH];

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic          push_fire;
    logic          pop_fire;
    logic [31:0]   head_word;

    // Readiness is judged on the registered count only, so a full queue
    // refuses a push even when a pop fires in the same cycle.
    assign push_ready_out = (count < FULL_COUNT) & ~flush_in & ~reset_in;
    assign pop_valid_out  = (count != '0) & ~flush_in;

    assign push_fire = push_valid_in & push_ready_out;
    assign pop_fire  = pop_ready_in & pop_valid_out;

    always_ff @(posedge clk_in) begin
        if (push_fire) begin
            instr_mem[wr_ptr] <= mp_instr_in;
            pc_mem[wr_ptr]    <= pc_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in || flush_in) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_fire) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_fire, pop_fire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Head selection: NOP and PC 0 whenever no valid entry is presented,
    // which also covers the flush cycle itself.
    always_comb begin
        head_word = NOP_INSTR;
        pc_out    = '0;
        if (pop_valid_out) begin
            head_word = instr_mem[rd_ptr];
            pc_out    = pc_mem[rd_ptr];
        end
    end

    assign opcode_out   = head_word[6:0];
    assign rdaddr_out   = head_word[11:7];
    assign funct3_out   = head_word[14:12];
    assign rs1addr_out  = head_word[19:15];
    assign rs2addr_out  = head_word[24:20];
    assign funct7_out   = head_word[31:25];
    assign csr_addr_out = head_word[31:20];
    assign instr_out    = head_word[31:7];
    assign count_out    = count;

endmodule

// File: tb/tb_instruction_buffer_mux.sv
// tb/tb_instruction_buffer_mux.sv - directed self-checking bench for instruction_buffer_mux

module tb_instruction_buffer_mux;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        flush_in;
    logic        push_valid_in;
    logic        push_ready_out;
    logic [31:0] mp_instr_in;
    logic [31:0] pc_in;
    logic        pop_ready_in;
    logic        pop_valid_out;
    logic [31:0] pc_out;
    logic [6:0]  opcode_out;
    logic [2:0]  funct3_out;
    logic [6:0]  funct7_out;
    logic [4:0]  rs1addr_out;
    logic [4:0]  rs2addr_out;
    logic [4:0]  rdaddr_out;
    logic [11:0] csr_addr_out;
    logic [24:0] instr_out;
    logic [2:0]  count_out;

    int tests = 0;
    int fails = 0;

    always #5 clk_in = ~clk_in;

    instruction_buffer_mux #(
        .DEPTH(4),
        .PC_W(32),
        .NOP_INSTR(32'h00000013)
    ) dut (
        .clk_in(clk_in),
        .reset_in(reset_in),
        .flush_in(flush_in),
        .push_valid_in(push_valid_in),
        .push_ready_out(push_ready_out),
        .mp_instr_in(mp_instr_in),
        .pc_in(pc_in),
        .pop_ready_in(pop_ready_in),
        .pop_valid_out(pop_valid_out),
        .pc_out(pc_out),
        .opcode_out(opcode_out),
        .funct3_out(funct3_out),
        .funct7_out(funct7_out),
        .rs1addr_out(rs1addr_out),
        .rs2addr_out(rs2addr_out),
        .rdaddr_out(rdaddr_out),
        .csr_addr_out(csr_addr_out),
        .instr_out(instr_out),
        .count_out(count_out)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; leave the bench sitting on the falling edge.
    task automatic step();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    function automatic logic [31:0] yword(input int k);
        yword = {7'(k), 5'(k + 1), 5'(k + 2), 3'(k), 5'(k + 3), 7'h33};
    endfunction

    logic [31:0] words [5];
    logic [31:0] pcs   [5];
    logic [31:0] head;

    initial begin
        words[0] = 32'h00100093; pcs[0] = 32'h200;
        words[1] = 32'h00208113; pcs[1] = 32'h204;
        words[2] = 32'h00310193; pcs[2] = 32'h208;
        words[3] = 32'h00418213; pcs[3] = 32'h20C;
        words[4] = 32'h00520293; pcs[4] = 32'h210;

        reset_in = 1'b1; flush_in = 1'b0; push_valid_in = 1'b0;
        pop_ready_in = 1'b0; mp_instr_in = '0; pc_in = '0;
        @(negedge clk_in);
        check("push_ready_in_reset", 64'(push_ready_out), 64'd0);
        step();
        step();
        reset_in = 1'b0;
        #1;

        // Idle after reset
        check("rst_count", 64'(count_out), 64'd0);
        check("rst_pop_valid", 64'(pop_valid_out), 64'd0);
        check("rst_opcode", 64'(opcode_out), 64'h13);
        check("rst_instr", 64'(instr_out), 64'h0);
        check("rst_pc", 64'(pc_out), 64'h0);
        check("rst_push_ready", 64'(push_ready_out), 64'd1);
        check("rst_rd", 64'(rdaddr_out), 64'd0);
        check("rst_funct3", 64'(funct3_out), 64'd0);

        // Single push of addi x5,x5,10
        push_valid_in = 1'b1; mp_instr_in = 32'h00A28293; pc_in = 32'h100;
        step();
        push_valid_in = 1'b0;
        #1;
        check("p1_pop_valid", 64'(pop_valid_out), 64'd1);
        check("p1_opcode", 64'(opcode_out), 64'h13);
        check("p1_rd", 64'(rdaddr_out), 64'd5);
        check("p1_rs1", 64'(rs1addr_out), 64'd5);
        check("p1_funct3", 64'(funct3_out), 64'd0);
        check("p1_csr", 64'(csr_addr_out), 64'h00A);
        check("p1_instr", 64'(instr_out), 64'h0014505);
        check("p1_pc", 64'(pc_out), 64'h100);
        check("p1_count", 64'(count_out), 64'd1);

        pop_ready_in = 1'b1;
        step();
        pop_ready_in = 1'b0;
        #1;
        check("p1_pop_count", 64'(count_out), 64'd0);
        check("p1_pop_valid_after", 64'(pop_valid_out), 64'd0);

        // Fill from pointer 1 so the pointers wrap; the fifth word is held off
        for (int i = 0; i < 5; i++) begin
            push_valid_in = 1'b1; mp_instr_in = words[i]; pc_in = pcs[i];
            #1;
            check($sformatf("fill_ready_%0d", i), 64'(push_ready_out), (i < 4) ? 64'd1 : 64'd0);
            if (i < 4) step();
        end
        check("full_count", 64'(count_out), 64'd4);

        // Full with push and pop together: pop only
        pop_ready_in = 1'b1;
        #1;
        check("full_both_ready", 64'(push_ready_out), 64'd0);
        head = {instr_out, opcode_out};
        check("full_both_head", 64'(head), 64'(words[0]));
        check("full_both_pc", 64'(pc_out), 64'(pcs[0]));
        step();
        pop_ready_in = 1'b0;
        #1;
        check("full_both_count", 64'(count_out), 64'd3);
        check("retry_ready", 64'(push_ready_out), 64'd1);
        step();
        push_valid_in = 1'b0;
        #1;
        check("retry_count", 64'(count_out), 64'd4);

        // Drain remaining entries in order across the wrap
        pop_ready_in = 1'b1;
        for (int i = 1; i < 5; i++) begin
            #1;
            head = {instr_out, opcode_out};
            check($sformatf("drain_word_%0d", i), 64'(head), 64'(words[i]));
            check($sformatf("drain_pc_%0d", i), 64'(pc_out), 64'(pcs[i]));
            step();
        end
        pop_ready_in = 1'b0;
        #1;
        check("drain_count", 64'(count_out), 64'd0);

        // Three entries then flush with a push offered
        for (int i = 0; i < 3; i++) begin
            push_valid_in = 1'b1; mp_instr_in = words[i]; pc_in = pcs[i];
            step();
        end
        check("pre_flush_count", 64'(count_out), 64'd3);
        flush_in = 1'b1; mp_instr_in = words[4]; pc_in = pcs[4];
        #1;
        check("flush_pop_valid", 64'(pop_valid_out), 64'd0);
        check("flush_opcode", 64'(opcode_out), 64'h13);
        check("flush_instr", 64'(instr_out), 64'h0);
        check("flush_rs1", 64'(rs1addr_out), 64'd0);
        check("flush_pc", 64'(pc_out), 64'h0);
        check("flush_push_ready", 64'(push_ready_out), 64'd0);
        step();
        flush_in = 1'b0; push_valid_in = 1'b0;
        #1;
        check("post_flush_count", 64'(count_out), 64'd0);
        check("post_flush_valid", 64'(pop_valid_out), 64'd0);

        // Two entries, then ten cycles of simultaneous push and pop
        for (int k = 0; k < 2; k++) begin
            push_valid_in = 1'b1; mp_instr_in = yword(k); pc_in = 32'h400 + 32'(4 * k);
            step();
        end
        pop_ready_in = 1'b1;
        for (int k = 0; k < 10; k++) begin
            mp_instr_in = yword(k + 2); pc_in = 32'h400 + 32'(4 * (k + 2));
            #1;
            head = {instr_out, opcode_out};
            check($sformatf("steady_word_%0d", k), 64'(head), 64'(yword(k)));
            check($sformatf("steady_pc_%0d", k), 64'(pc_out), 64'(32'h400 + 32'(4 * k)));
            check($sformatf("steady_count_%0d", k), 64'(count_out), 64'd2);
            step();
        end
        pop_ready_in = 1'b0; push_valid_in = 1'b0;
        #1;
        check("steady_end_count", 64'(count_out), 64'd2);
        head = {instr_out, opcode_out};
        check("steady_end_head", 64'(head), 64'(yword(10)));

        // Mid-stream reset
        reset_in = 1'b1;
        step();
        reset_in = 1'b0;
        #1;
        check("rst2_count", 64'(count_out), 64'd0);
        check("rst2_pop_valid", 64'(pop_valid_out), 64'd0);
        check("rst2_opcode", 64'(opcode_out), 64'h13);
        check("rst2_instr", 64'(instr_out), 64'h0);
        check("rst2_pc", 64'(pc_out), 64'h0);
        check("rst2_push_ready", 64'(push_ready_out), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
